// File: rtl/hex_digit_counter.sv
// hex_digit_counter: rate-divided 4-bit up/down counter that feeds a 7-segment
// hex decoder. It has a programmable tick divider, a synchronous parallel load,
// an enable and a direction control.
// Optional feature macro: HEX_DIGIT_COUNTER_CARRY_EN adds a registered `carry`
// output that pulses when a step wraps the digit.
module hex_digit_counter #(
    parameter int unsigned DIV_BASE = 50000000,
    parameter int unsigned DIV_W    = 28
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       en,
    input  logic       up,
    input  logic [1:0] speed,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       tick
`ifdef HEX_DIGIT_COUNTER_CARRY_EN
    ,
    output logic       carry
`endif
);

    // Divider reload values: PERIOD(speed) - 1
    localparam logic [DIV_W-1:0] PM1_S0 = DIV_W'(0);
    localparam logic [DIV_W-1:0] PM1_S1 = DIV_W'(DIV_BASE - 1);
    localparam logic [DIV_W-1:0] PM1_S2 = DIV_W'((2 * DIV_BASE) - 1);
    localparam logic [DIV_W-1:0] PM1_S3 = DIV_W'((4 * DIV_BASE) - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_speed_q;
    logic [3:0]       r_digit;
    logic             r_tick;

    logic [DIV_W-1:0] w_period_m1;
    logic [DIV_W-1:0] w_div_nxt;
    logic [3:0]       w_digit_nxt;
    logic             w_tick_nxt;
    logic             w_sel_chg;
    logic             w_step;

    assign w_sel_chg = (speed != r_speed_q);
    assign w_step    = en & (r_div_cnt == DIV_W'(0)) & ~load & ~w_sel_chg;

    // Reload value selected by the live speed input
    always_comb begin
        w_period_m1 = PM1_S0;
        case (speed)
            2'b00: w_period_m1 = PM1_S0;
            2'b01: w_period_m1 = PM1_S1;
            2'b10: w_period_m1 = PM1_S2;
            2'b11: w_period_m1 = PM1_S3;
            default: w_period_m1 = PM1_S0;
        endcase
    end

    // Next-state: load > speed change > step > countdown > hold
    always_comb begin
        w_digit_nxt = r_digit;
        w_div_nxt   = r_div_cnt;
        w_tick_nxt  = 1'b0;
        if (load) begin
            w_digit_nxt = load_val;
            w_div_nxt   = w_period_m1;
        end else if (w_sel_chg) begin
            w_div_nxt   = w_period_m1;
        end else if (w_step) begin
            w_digit_nxt = up ? (r_digit + 4'd1) : (r_digit - 4'd1);
            w_div_nxt   = w_period_m1;
            w_tick_nxt  = 1'b1;
        end else if (en) begin
            w_div_nxt   = r_div_cnt - DIV_W'(1);
        end
    end

    // State registers
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_div_cnt <= '0;
            r_speed_q <= 2'b00;
            r_digit   <= 4'h0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_speed_q <= speed;
            r_digit   <= w_digit_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    assign digit = r_digit;
    assign tick  = r_tick;

`ifdef HEX_DIGIT_COUNTER_CARRY_EN
    logic r_carry;
    logic w_wrap;

    // Step about to leave F going up, or 0 going down
    assign w_wrap = up ? (r_digit == 4'hF) : (r_digit == 4'h0);

    // Carry pulse aligned with the wrapping step's tick
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_carry <= 1'b0;
        end else begin
            r_carry <= w_step & w_wrap;
        end
    end

    assign carry = r_carry;
`endif

endmodule

// File: tb/tb_hex_digit_counter.sv
// Scoreboard bench for hex_digit_counter with DIV_BASE = 4.
// The driver pushes the hand-computed expected outputs for each edge. A monitor
// pops them after each clock edge, and also when reset is asserted.
module tb_hex_digit_counter;

    localparam int unsigned DIV_BASE = 4;
    localparam int unsigned DIV_W    = 8;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       en       = 1'b0;
    logic       up       = 1'b1;
    logic [1:0] speed    = 2'b00;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'h0;
    logic [3:0] digit;
    logic       tick;
`ifdef HEX_DIGIT_COUNTER_CARRY_EN
    logic       carry;
`endif

    typedef struct packed {
        logic [3:0] d;
        logic       t;
        logic       c;
    } exp_t;

    exp_t exp_q[$];
    int   id_q[$];
    exp_t mon_e;
    int   mon_id;
    int   n_push = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    hex_digit_counter #(
        .DIV_BASE(DIV_BASE),
        .DIV_W   (DIV_W)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .en      (en),
        .up      (up),
        .speed   (speed),
        .load    (load),
        .load_val(load_val),
        .digit   (digit),
        .tick    (tick)
`ifdef HEX_DIGIT_COUNTER_CARRY_EN
        ,
        .carry   (carry)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Monitor: compare outputs against the head of the scoreboard
    initial begin
        forever begin
            @(posedge CLOCK_50 or negedge resetn);
            #1;
            if (exp_q.size() > 0) begin
                mon_e  = exp_q.pop_front();
                mon_id = id_q.pop_front();
                n_vec++;
                if (digit !== mon_e.d) begin
                    n_err++;
                    $display("FAIL digit vec%0d: got %h expected %h", mon_id, digit, mon_e.d);
                end
                if (tick !== mon_e.t) begin
                    n_err++;
                    $display("FAIL tick vec%0d: got %b expected %b", mon_id, tick, mon_e.t);
                end
`ifdef HEX_DIGIT_COUNTER_CARRY_EN
                if (carry !== mon_e.c) begin
                    n_err++;
                    $display("FAIL carry vec%0d: got %b expected %b", mon_id, carry, mon_e.c);
                end
`endif
            end
        end
    end

    // Drive inputs at a falling edge and queue the outputs expected after the next rise
    task automatic cyc(input logic i_en, input logic i_up, input logic [1:0] i_spd,
                       input logic i_ld, input logic [3:0] i_lv,
                       input logic [3:0] ed, input logic et, input logic ec);
        exp_t e;
        en       = i_en;
        up       = i_up;
        speed    = i_spd;
        load     = i_ld;
        load_val = i_lv;
        e.d = ed;
        e.t = et;
        e.c = ec;
        exp_q.push_back(e);
        id_q.push_back(n_push);
        n_push++;
        @(negedge CLOCK_50);
    endtask

    // Assert reset between edges and expect cleared outputs immediately
    task automatic reset_mid();
        exp_t e;
        e.d = 4'h0;
        e.t = 1'b0;
        e.c = 1'b0;
        exp_q.push_back(e);
        id_q.push_back(n_push);
        n_push++;
        resetn = 1'b0;
        @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    initial begin
        @(negedge CLOCK_50);
        // Reset state, still held in reset
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        resetn = 1'b1;

        // Speed 00: step on every edge, wrap F->0 at the 16th edge
        for (int i = 1; i <= 18; i++)
            cyc(1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 4'(i), 1'b1, (i == 16));

        // Speed 01: speed change on edge 1, then steps at edges 5 and 9
        for (int i = 1; i <= 12; i++)
            cyc(1'b1, 1'b1, 2'd1, 1'b0, 4'h0,
                (i < 5) ? 4'h2 : ((i < 9) ? 4'h3 : 4'h4), (i == 5 || i == 9), 1'b0);

        // Load collides with a due step; the next step follows 4 edges later
        cyc(1'b1, 1'b1, 2'd1, 1'b1, 4'hA, 4'hA, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 2'd1, 1'b0, 4'h0, 4'hA, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 2'd1, 1'b0, 4'h0, 4'hB, 1'b1, 1'b0);

        // Load 7, then reset mid-period
        cyc(1'b1, 1'b1, 2'd1, 1'b1, 4'h7, 4'h7, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 2'd1, 1'b0, 4'h0, 4'h7, 1'b0, 1'b0);
        reset_mid();

        // After reset at speed 01: speed-change edge, then the first step on edge 5
        for (int i = 1; i <= 5; i++)
            cyc(1'b1, 1'b1, 2'd1, 1'b0, 4'h0, (i == 5) ? 4'h1 : 4'h0, (i == 5), 1'b0);

        // Load works while disabled; the digit then holds
        cyc(1'b0, 1'b1, 2'd1, 1'b1, 4'h5, 4'h5, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0);

        // Speed 11 counting down from a load of 2: 1, 0, F at 16-edge spacing
        cyc(1'b1, 1'b0, 2'd3, 1'b1, 4'h2, 4'h2, 1'b0, 1'b0);
        for (int i = 1; i <= 48; i++)
            cyc(1'b1, 1'b0, 2'd3, 1'b0, 4'h0, 4'(2 - (i / 16)), ((i % 16) == 0), (i == 48));

        // Speed 10 with a 5-edge enable gap: the step moves from edge 9 to edge 14
        cyc(1'b1, 1'b1, 2'd2, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 2'd2, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b1, 2'd2, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 2'd2, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 2'd2, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            cyc(1'b1, 1'b1, 2'd2, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

        // Switch 10 -> 01: no step on the change edge; the next step comes 4 edges later
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 2'd1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 2'd1, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0);

        // Bounded drain of the scoreboard
        for (int k = 0; k < 4 && exp_q.size() > 0; k++)
            @(negedge CLOCK_50);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
